// File: rtl/array_mult_pkg.sv
// Shared sizing helpers for the pipelined array multiplier.
package array_mult_pkg;

  // Number of pipeline stages: the last stage absorbs any partial group of rows.
  function automatic int stages(input int width, input int rows_per_stage);
    return (width + rows_per_stage - 1) / rows_per_stage;
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/array_mult_row.sv
// One combinational adder row: adds (a & b_bit) << ROW into the accumulator with an
// HA at column ROW and an FA chain above it. Signed mode: ARRAY_MULT_SIGNED_EN.
module array_mult_row
  import array_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 1
) (
  input  logic [prod_w(WIDTH)-1:0] acc_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic                     b_bit_i,
  output logic [prod_w(WIDTH)-1:0] acc_o
);

  localparam int PW = prod_w(WIDTH);

`ifdef ARRAY_MULT_SIGNED_EN
  // Baugh-Wooley: the sign row inverts all but its MSB term; other rows invert only their MSB term.
  localparam logic [WIDTH-1:0] INV_MASK = (ROW == WIDTH - 1) ?
                                          {1'b0, {(WIDTH-1){1'b1}}} :
                                          {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    pp_ext;
  logic             carry;

  // NOTE: combinational ripple uses blocking '=' so each column sees the carry just computed.
  always_comb begin
    pp = a_i & {WIDTH{b_bit_i}};
`ifdef ARRAY_MULT_SIGNED_EN
    pp = pp ^ INV_MASK;
`endif
    pp_ext = {{(PW-WIDTH){1'b0}}, pp} << ROW;
    acc_o  = acc_i;
    carry  = 1'b0;
    for (int col = ROW; col < PW; col++) begin
      acc_o[col] = acc_i[col] ^ pp_ext[col] ^ carry;
      carry      = (acc_i[col] & pp_ext[col]) | (carry & (acc_i[col] ^ pp_ext[col]));
    end
  end

endmodule

// File: rtl/array_mult_pipe.sv
// Pipelined WIDTHxWIDTH array multiplier with valid/ready handshakes and a register
// after every ROWS_PER_STAGE adder rows. Signed (Baugh-Wooley) mode: ARRAY_MULT_SIGNED_EN.
module array_mult_pipe
  import array_mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int L  = stages(WIDTH, ROWS_PER_STAGE);
  localparam int PW = prod_w(WIDTH);

  logic [L-1:0]                valid_q, valid_d;
  logic [L-1:0][WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [L-1:0][PW-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0][PW-1:0]    row_acc;
  logic                        en;

  assign out_valid = valid_q[L-1];
  assign prod      = acc_q[L-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !rst;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LAST_ROW = (((s + 1) * ROWS_PER_STAGE < WIDTH) ?
                               (s + 1) * ROWS_PER_STAGE : WIDTH) - 1;
    if (s == 0) begin : g_first
      assign valid_d[s] = in_valid;
      assign a_d[s]     = a;
      assign b_d[s]     = b;
    end else begin : g_next
      assign valid_d[s] = valid_q[s-1];
      assign a_d[s]     = a_q[s-1];
      assign b_d[s]     = b_q[s-1];
    end
    assign acc_d[s] = row_acc[LAST_ROW];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    localparam int S = i / ROWS_PER_STAGE;
    if (i == 0) begin : g_row0
`ifdef ARRAY_MULT_SIGNED_EN
      // The two Baugh-Wooley correction ones are folded into row 0.
      localparam logic [WIDTH-1:0] ROW0_INV   = {1'b1, {(WIDTH-1){1'b0}}};
      localparam logic [PW-1:0]    ROW0_CONST = (PW'(1) << (PW - 1)) | (PW'(1) << WIDTH);
      assign row_acc[i] = {{WIDTH{1'b0}}, (a & {WIDTH{b[0]}}) ^ ROW0_INV} | ROW0_CONST;
`else
      assign row_acc[i] = {{WIDTH{1'b0}}, a & {WIDTH{b[0]}}};
`endif
    end else begin : g_add
      logic [PW-1:0] acc_in;
      if (i % ROWS_PER_STAGE == 0) begin : g_from_reg
        assign acc_in = acc_q[S-1];
      end else begin : g_from_row
        assign acc_in = row_acc[i-1];
      end
      array_mult_row #(
        .WIDTH (WIDTH),
        .ROW   (i)
      ) u_row (
        .acc_i   (acc_in),
        .a_i     (a_d[S]),
        .b_bit_i (b_d[S][i]),
        .acc_o   (row_acc[i])
      );
    end
  end

  // Operand bits of rows already consumed, and the last stage's operands, are not needed.
  logic unused_ok;
  assign unused_ok = ^{a_q[L-1], b_q, b_d};

  // NOTE: state uses non-blocking '<=' so all stages shift off the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_array_mult_pipe.sv
// Self-checking bench for array_mult_pipe (WIDTH=8, ROWS_PER_STAGE=2, L=4); follows
// ARRAY_MULT_SIGNED_EN for the expected products.
module tb_array_mult_pipe;

  localparam int WIDTH = 8;
  localparam int RPS   = 2;
  localparam int L     = 4;

`ifdef ARRAY_MULT_SIGNED_EN
  localparam logic [15:0] LAT_EXP = 16'h0001;
`else
  localparam logic [15:0] LAT_EXP = 16'hFE01;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*WIDTH-1:0] prod;

  array_mult_pipe #(
    .WIDTH          (WIDTH),
    .ROWS_PER_STAGE (RPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_p;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vp);
    vec_t v;
    v.a = va;
    v.b = vb;
    v.p = vp;
    vecs.push_back(v);
  endtask

  // Sample both handshakes before the edge, score any output, then advance one cycle.
  task automatic tick(output bit did_in, output bit did_out);
    logic [15:0] e;
    did_in  = in_valid && in_ready;
    did_out = out_valid && out_ready;
    if (did_out) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 16'hxxxx;
      check("prod_order", prod, e);
    end
    @(posedge clk);
    #1;
    if (did_in) exp_q.push_back(cur_p);
  endtask

  task automatic run_stream(input int stall_at, input int stall_len, input int gap_every,
                            input string tag);
    int          idx = 0;
    int          outs = 0;
    int          cyc = 0;
    int          first_out = -1;
    int          last_out = -1;
    logic [15:0] held = '0;
    bit          di, dout, stalling;
    exp_q.delete();
    while ((idx < vecs.size() || exp_q.size() != 0) && cyc < 300) begin
      stalling  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalling;
      if (idx < vecs.size() && !(gap_every > 0 && (cyc % gap_every) == gap_every - 1)) begin
        in_valid = 1'b1;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        cur_p    = vecs[idx].p;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalling) begin
        check({tag, "_stall_out_valid"}, out_valid, 1);
        check({tag, "_stall_in_ready"}, in_ready, 0);
        if (cyc == stall_at) held = prod;
        else                 check({tag, "_stall_prod_held"}, prod, held);
      end
      tick(di, dout);
      if (di) idx++;
      if (dout) begin
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_no_timeout"}, cyc < 300, 1);
    check({tag, "_out_count"}, outs, vecs.size());
    if (stall_len == 0 && gap_every == 0) begin
      check({tag, "_first_latency"}, first_out, L);
      check({tag, "_consecutive"}, last_out - first_out + 1, outs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef ARRAY_MULT_SIGNED_EN
    add(8'h80, 8'h80, 16'h4000);
    add(8'hFF, 8'h01, 16'hFFFF);
    add(8'h80, 8'h7F, 16'hC080);
    add(8'h00, 8'hFB, 16'h0000);
    add(8'h03, 8'h05, 16'h000F);
    add(8'hFD, 8'h05, 16'hFFF1);
    add(8'hF9, 8'hF7, 16'h003F);
    add(8'h7F, 8'h7F, 16'h3F01);
    add(8'hFE, 8'h64, 16'hFF38);
    add(8'h01, 8'hFF, 16'hFFFF);
`else
    add(3,   5,   15);    add(0,   200, 0);     add(1,   1,   1);     add(128, 2,   256);
    add(255, 1,   255);   add(2,   255, 510);   add(16,  16,  256);   add(15,  15,  225);
    add(100, 100, 10000); add(255, 0,   0);     add(200, 3,   600);   add(17,  19,  323);
    add(64,  4,   256);   add(12,  12,  144);   add(99,  2,   198);   add(7,   8,   56);
    add(255, 254, 64770); add(129, 129, 16641); add(170, 85,  14450); add(13,  11,  143);
`endif

    // Reset held 3 cycles with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd5; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_prod", prod, 0);
      check("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Latency: operands presented now, captured at edge 1, product visible after edge 4.
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    for (int e = 1; e <= L; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) in_valid = 1'b0;
      if (e < L) check("lat_early_valid", out_valid, 0);
    end
    check("lat_out_valid", out_valid, 1);
    check("lat_prod", prod, LAT_EXP);
    @(posedge clk);
    #1;
    check("lat_drained", out_valid, 0);

    run_stream(1000, 0, 0, "stream");
    run_stream(8, 6, 0, "backpressure");
    run_stream(1000, 0, 3, "bubbles");

    // Reset with three products in flight; none may emerge, then 7x9 flows normally.
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'd11; b = 8'd13; @(posedge clk); #1;
    a = 8'd5;  b = 8'd6;  @(posedge clk); #1;
    a = 8'd9;  b = 8'd9;  @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd9;
    for (int e = 1; e <= L; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) in_valid = 1'b0;
      if (e < L) check("midrst_no_emit", out_valid, 0);
    end
    check("midrst_out_valid_63", out_valid, 1);
    check("midrst_prod_63", prod, 63);
    @(posedge clk);
    #1;
    check("midrst_single", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
